bcd_calc_datapath: RTL and testbench

BCD_CALC_DATAPATH -- requirements
Module: bcd_calc_datapath

---
 rtl/bcd_calc_datapath_if.sv | 26 ++
 rtl/bcd_calc_datapath.sv | 185 ++++++++++++++++++
 tb/tb_bcd_calc_datapath.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/bcd_calc_datapath_if.sv
// Command/result bundle for bcd_calc_datapath: the master issues level-requested
// commands, the slave returns four-phase ack, status flags and BCD results.
interface bcd_calc_datapath_if #(
    parameter int WIDTH  = 7,
    parameter int DIGITS = 3
);
    logic [WIDTH-1:0]    input_value;
    logic [2:0]          cmd;
    logic                cmd_req;
    logic                cmd_ack;
    logic                busy;
    logic                cmd_err;
    logic                negative;
    logic [7:0]          output_value;
    logic [4*DIGITS-1:0] bcd_full;

    modport master (
        output input_value, cmd, cmd_req,
        input  cmd_ack, busy, cmd_err, negative, output_value, bcd_full
    );

    modport slave (
        input  input_value, cmd, cmd_req,
        output cmd_ack, busy, cmd_err, negative, output_value, bcd_full
    );
endinterface

// File: rtl/bcd_calc_datapath.sv
// Two-operand BCD calculator: ack 2 edges after request (WIDTH+3 for conversions), four-phase req/ack.
// Define BCD_CALC_SUB_EN to enable the SUB command (|A-B| with sign flag); otherwise cmd 7 is illegal.
module bcd_calc_datapath #(
    parameter int WIDTH  = 7,
    parameter int DIGITS = 3
) (
    input  logic                  clock,
    input  logic                  reset_n,
    bcd_calc_datapath_if.slave    bus
);
    localparam int DW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_CONVERT, S_ACK} state_t;
    typedef enum logic [2:0] {
        C_INIT, C_LOAD_A, C_LOAD_B, C_DISP_A, C_DISP_B, C_DISP_LS, C_DISP_MS, C_SUB
    } cmd_t;

    state_t           state_q, state_d;
    cmd_t             cmd_q, cmd_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH:0]   bin_q, bin_d;
    logic [DW-1:0]    dig_q, dig_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [7:0]       out_q, out_d;
    logic [DW-1:0]    full_q, full_d;
    logic             ack_q, ack_d, busy_q, busy_d, err_q, err_d;
    logic [DW-1:0]    dig_adj, dig_shift;
    logic [15:0]      full_pad;
    logic [WIDTH:0]   sum;
`ifdef BCD_CALC_SUB_EN
    logic             neg_q, neg_d;
    logic [WIDTH:0]   diff;
    assign diff = (a_q >= b_q) ? {1'b0, a_q - b_q} : {1'b0, b_q - a_q};
`endif

    assign sum = {1'b0, a_q} + {1'b0, b_q};

    // Double-dabble step: add 3 to every digit >= 5, then shift the next binary bit in.
    always_comb begin
        dig_adj = dig_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (dig_q[4*i +: 4] > 4'd4) dig_adj[4*i +: 4] = dig_q[4*i +: 4] + 4'd3;
        end
        dig_shift = {dig_adj[DW-2:0], bin_q[WIDTH]};
    end

    // Digit 3 reads as zero when the result has only three digits.
    always_comb begin
        full_pad         = '0;
        full_pad[DW-1:0] = full_q;
    end

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        opnd_d  = opnd_q;
        a_d     = a_q;
        b_d     = b_q;
        bin_d   = bin_q;
        dig_d   = dig_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        full_d  = full_q;
        err_d   = err_q;
        ack_d   = 1'b0;
`ifdef BCD_CALC_SUB_EN
        neg_d   = neg_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.cmd_req) begin
                    cmd_d   = cmd_t'(bus.cmd);
                    opnd_d  = bus.input_value;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                err_d   = 1'b0;
                state_d = S_ACK;
                dig_d   = '0;
                cnt_d   = '0;
                case (cmd_q)
                    C_INIT: begin
                        a_d    = '0;
                        b_d    = '0;
                        out_d  = '0;
                        full_d = '0;
`ifdef BCD_CALC_SUB_EN
                        neg_d  = 1'b0;
`endif
                    end
                    C_LOAD_A:  a_d   = opnd_q;
                    C_LOAD_B:  b_d   = opnd_q;
                    C_DISP_MS: out_d = full_pad[15:8];
                    C_DISP_A, C_DISP_B, C_DISP_LS: begin
                        bin_d   = (cmd_q == C_DISP_A) ? {1'b0, a_q} :
                                  (cmd_q == C_DISP_B) ? {1'b0, b_q} : sum;
                        state_d = S_CONVERT;
`ifdef BCD_CALC_SUB_EN
                        neg_d   = 1'b0;
`endif
                    end
`ifdef BCD_CALC_SUB_EN
                    C_SUB: begin
                        bin_d   = diff;
                        neg_d   = (b_q > a_q);
                        state_d = S_CONVERT;
                    end
`endif
                    default:   err_d = 1'b1;
                endcase
            end
            S_CONVERT: begin
                bin_d = {bin_q[WIDTH-1:0], 1'b0};
                dig_d = dig_shift;
                if (cnt_q == CW'(WIDTH)) begin
                    full_d  = dig_shift;
                    out_d   = dig_shift[7:0];
                    state_d = S_ACK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_ACK: begin
                ack_d = 1'b1;
                if (ack_q && !bus.cmd_req) begin
                    ack_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cmd_q   <= C_INIT;
            opnd_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            bin_q   <= '0;
            dig_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            full_q  <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            opnd_q  <= opnd_d;
            a_q     <= a_d;
            b_q     <= b_d;
            bin_q   <= bin_d;
            dig_q   <= dig_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            full_q  <= full_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

`ifdef BCD_CALC_SUB_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) neg_q <= 1'b0;
        else          neg_q <= neg_d;
    end
    assign bus.negative = neg_q;
`else
    assign bus.negative = 1'b0;
`endif

    assign bus.cmd_ack      = ack_q;
    assign bus.busy         = busy_q;
    assign bus.cmd_err      = err_q;
    assign bus.output_value = out_q;
    assign bus.bcd_full     = full_q;
endmodule

// File: tb/tb_bcd_calc_datapath.sv
// Scoreboard bench for bcd_calc_datapath: a reference model pushes expected results per command,
// popped and compared when cmd_ack is observed.
module tb_bcd_calc_datapath;
    localparam int W = 7;
    localparam int D = 3;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    bcd_calc_datapath_if #(.WIDTH(W), .DIGITS(D)) bus ();
    bcd_calc_datapath #(.WIDTH(W), .DIGITS(D)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [7:0]     out;
        logic [4*D-1:0] full;
        logic           neg;
        logic           err;
        int             lat;
    } exp_t;

    exp_t           sb[$];
    int             n_tests = 0;
    int             n_fail  = 0;
    logic [W-1:0]   m_a, m_b;
    logic [7:0]     m_out;
    logic [4*D-1:0] m_full;
    logic           m_neg, m_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    task automatic model_reset();
        m_a = '0; m_b = '0; m_out = '0; m_full = '0; m_neg = 1'b0; m_err = 1'b0;
    endtask

    task automatic push_model(input int c, input int v);
        exp_t e;
        bit   conv = 1'b0;
        int   x    = 0;
        case (c)
            0: model_reset();
            1: begin m_a = W'(v); m_err = 1'b0; end
            2: begin m_b = W'(v); m_err = 1'b0; end
            3: begin x = int'(m_a); conv = 1'b1; m_neg = 1'b0; end
            4: begin x = int'(m_b); conv = 1'b1; m_neg = 1'b0; end
            5: begin x = int'(m_a) + int'(m_b); conv = 1'b1; m_neg = 1'b0; end
            6: begin m_out = {4'h0, m_full[11:8]}; m_err = 1'b0; end
            default: begin
`ifdef BCD_CALC_SUB_EN
                x     = (m_a >= m_b) ? int'(m_a) - int'(m_b) : int'(m_b) - int'(m_a);
                m_neg = (m_b > m_a);
                conv  = 1'b1;
`else
                m_err = 1'b1;
`endif
            end
        endcase
        if (conv) begin
            m_full = to_bcd(x);
            m_out  = m_full[7:0];
            m_err  = 1'b0;
        end
        e.out  = m_out;
        e.full = m_full;
        e.neg  = m_neg;
        e.err  = m_err;
        e.lat  = conv ? W + 3 : 2;
        sb.push_back(e);
    endtask

    task automatic run_cmd(input int c, input int v, input int hold);
        exp_t e;
        int   n   = 0;
        bit   got = 1'b0;
        @(negedge clock);
        bus.cmd         = 3'(c);
        bus.input_value = W'(v);
        bus.cmd_req     = 1'b1;
        push_model(c, v);
        @(posedge clock);
        #1;
        bus.cmd         = ~bus.cmd;
        bus.input_value = W'($urandom);
        while (!got && n < 40) begin
            @(posedge clock);
            #1;
            n++;
            if (n == 1) check("busy_k1", {31'd0, bus.busy}, 32'd1);
            if (bus.cmd_ack) got = 1'b1;
        end
        e = sb.pop_front();
        if (!got) check("ack_timeout", 32'd0, 32'd1);
        else      check("ack_latency", n, e.lat);
        check("busy_at_ack", {31'd0, bus.busy}, 32'd1);
        check("output_value", {24'd0, bus.output_value}, {24'd0, e.out});
        check("bcd_full", {20'd0, bus.bcd_full}, {20'd0, e.full});
        check("negative", {31'd0, bus.negative}, {31'd0, e.neg});
        check("cmd_err", {31'd0, bus.cmd_err}, {31'd0, e.err});
        for (int i = 0; i < hold; i++) begin
            @(posedge clock);
            #1;
            check("ack_hold", {31'd0, bus.cmd_ack}, 32'd1);
            check("busy_hold", {31'd0, bus.busy}, 32'd1);
        end
        @(negedge clock);
        bus.cmd_req = 1'b0;
        @(posedge clock);
        #1;
        check("ack_drop", {31'd0, bus.cmd_ack}, 32'd0);
        check("busy_drop", {31'd0, bus.busy}, 32'd0);
        check("out_stable", {24'd0, bus.output_value}, {24'd0, e.out});
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ack"}, {31'd0, bus.cmd_ack}, 32'd0);
        check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
        check({tag, "_err"}, {31'd0, bus.cmd_err}, 32'd0);
        check({tag, "_neg"}, {31'd0, bus.negative}, 32'd0);
        check({tag, "_out"}, {24'd0, bus.output_value}, 32'd0);
        check({tag, "_full"}, {20'd0, bus.bcd_full}, 32'd0);
    endtask

    initial begin
        bus.cmd         = 3'd0;
        bus.input_value = '0;
        bus.cmd_req     = 1'b0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        check_all_zero("reset");
        @(negedge clock);
        reset_n = 1'b1;

        run_cmd(0, 0, 0);
        run_cmd(1, 99, 0);
        run_cmd(2, 99, 0);
        run_cmd(5, 0, 0);
        run_cmd(6, 0, 0);

        run_cmd(1, 127, 0);
        run_cmd(2, 127, 0);
        run_cmd(5, 0, 0);
        run_cmd(6, 0, 0);

        run_cmd(1, 7, 0);
        run_cmd(3, 0, 0);

        run_cmd(1, 5, 0);
        run_cmd(2, 12, 0);
        run_cmd(7, 0, 0);
        run_cmd(4, 0, 0);

        for (int i = 0; i < 4; i++) begin
            run_cmd(1, int'($urandom_range(0, 127)), 0);
            run_cmd(2, int'($urandom_range(0, 127)), 0);
            run_cmd(5, 0, 0);
            run_cmd(6, 0, 0);
        end

        run_cmd(1, 42, 5);
        run_cmd(3, 0, 0);

        // Reset in the middle of a conversion: everything clears at once, command is dropped.
        @(negedge clock);
        bus.cmd     = 3'd3;
        bus.cmd_req = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        check("conv_busy", {31'd0, bus.busy}, 32'd1);
        check("conv_no_ack", {31'd0, bus.cmd_ack}, 32'd0);
        #2;
        reset_n     = 1'b0;
        bus.cmd_req = 1'b0;
        #1;
        check_all_zero("midreset");
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        run_cmd(1, 3, 0);
        run_cmd(3, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
